// File: rtl/stereo_pixel_packer.sv
// stereo_pixel_packer
//   Packs one camera's raster-order grayscale pixel stream into words of
//   PIXELS_PER_WORD pixels. The first pixel of a word lands in the MSB slot.
//   Each finished word is written to the camera's frame BRAM at a linear
//   address, which equals row*WORDS_PER_ROW + x/PIXELS_PER_WORD.
//   frame_done_out pulses once the last word of a frame has been written.

module stereo_pixel_packer #(
    parameter int  PIXEL_WIDTH     = 8,
    parameter int  PIXELS_PER_WORD = 6,
    parameter int  IMG_WIDTH       = 240,
    parameter int  IMG_HEIGHT      = 320,
    localparam int WORDS_PER_ROW   = IMG_WIDTH / PIXELS_PER_WORD,
    localparam int DEPTH           = IMG_HEIGHT * WORDS_PER_ROW,
    localparam int AW              = $clog2(DEPTH),
    localparam int WORD_W          = PIXEL_WIDTH * PIXELS_PER_WORD
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   frame_start_in,
    input  logic                   pixel_valid_in,
    input  logic [PIXEL_WIDTH-1:0] pixel_in,
    output logic                   bram_we_out,
    output logic [AW-1:0]          bram_addr_out,
    output logic [WORD_W-1:0]      bram_din_out,
    output logic                   busy_out,
    output logic                   frame_done_out,
    output logic                   error_out
);

    localparam int CW     = $clog2(PIXELS_PER_WORD);
    localparam int PART_W = WORD_W - PIXEL_WIDTH;

    localparam logic [CW-1:0] LAST_SLOT = CW'(PIXELS_PER_WORD - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [CW-1:0]       pix_cnt;       // slot index of the next accepted pixel
    logic [PART_W-1:0]   partial_word;  // pixels already collected for the current word
    logic [AW-1:0]       addr_cnt;      // address of the next word to be written
    logic                frame_full;    // last word issued; waiting to enter DONE

    // Frame FSM, pixel packing, and registered BRAM write port.
    // NOTE: every register here is assigned with <= so all updates see the pre-edge values.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            // NOTE: the partial word is a plain register, so it is cleared like the rest; nothing is left half-packed.
            state          <= IDLE;
            pix_cnt        <= '0;
            partial_word   <= '0;
            addr_cnt       <= '0;
            frame_full     <= 1'b0;
            bram_we_out    <= 1'b0;
            bram_addr_out  <= '0;
            bram_din_out   <= '0;
            busy_out       <= 1'b0;
            frame_done_out <= 1'b0;
            error_out      <= 1'b0;
        end else begin
            bram_we_out    <= 1'b0;
            frame_done_out <= 1'b0;

            if (frame_start_in) begin
                // A start always begins a new frame; mid-frame it abandons the old one.
                if (state == PACK) begin
                    error_out <= 1'b1;
                end
                state      <= PACK;
                busy_out   <= 1'b1;
                addr_cnt   <= '0;
                frame_full <= 1'b0;
                if (pixel_valid_in) begin
                    partial_word <= PART_W'(pixel_in);
                    pix_cnt      <= CW'(1);
                end else begin
                    partial_word <= '0;
                    pix_cnt      <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        busy_out <= 1'b0;
                    end

                    PACK: begin
                        if (frame_full) begin
                            // The final write is on the port this cycle; pixels are ignored now.
                            state          <= DONE;
                            busy_out       <= 1'b0;
                            frame_done_out <= 1'b1;
                        end else if (pixel_valid_in) begin
                            if (pix_cnt == LAST_SLOT) begin
                                bram_we_out   <= 1'b1;
                                bram_addr_out <= addr_cnt;
                                bram_din_out  <= {partial_word, pixel_in};
                                pix_cnt       <= '0;
                                if (addr_cnt == LAST_ADDR) begin
                                    frame_full <= 1'b1;
                                end else begin
                                    addr_cnt <= addr_cnt + AW'(1);
                                end
                            end else begin
                                partial_word <= {partial_word[PART_W-PIXEL_WIDTH-1:0], pixel_in};
                                pix_cnt      <= pix_cnt + CW'(1);
                            end
                        end
                    end

                    DONE: begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end

                    default: begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
